// File: rtl/hazard_pkg.sv
// Shared types for the EV22 hazard/interlock controller: instruction type bit
// positions, the shadow-pipeline entry record and the jump-shadow FSM states.
package hazard_pkg;

  localparam int WR_READ  = 0;
  localparam int WR_WRITE = 1;
  localparam int R_READ   = 2;
  localparam int R_WRITE  = 3;
  localparam int C_READ   = 4;
  localparam int C_WRITE  = 5;
  localparam int JUMP     = 6;
  localparam int TYPE_W   = 7;

  // Destination field is sized for the widest supported register select;
  // narrower selects are zero-extended, so RADDR_W must not exceed DEST_W.
  localparam int DEST_W = 8;

  typedef struct packed {
    logic              valid;
    logic [TYPE_W-1:0] itype;
    logic [DEST_W-1:0] dest;
  } hz_entry_t;

  typedef enum logic {
    IDLE,
    SHADOW
  } hz_state_e;

  function automatic hz_entry_t hz_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// DEPTH-entry shift register of in-flight instruction descriptors; entry 0
// (e[1]) takes either the decode descriptor or a bubble.
module hazard_shadow_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bubble,
  input  hz_entry_t             din,
  output hz_entry_t [DEPTH-1:0] entries
);

  hz_entry_t [DEPTH-1:0] e_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_reg[0] <= hz_bubble();
    end else begin
      e_reg[0] <= bubble ? hz_bubble() : din;
    end
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (reset) begin
        e_reg[gi] <= hz_bubble();
      end else begin
        e_reg[gi] <= e_reg[gi-1];
      end
    end
  end

  assign entries = e_reg;

endmodule

// File: rtl/hazard_unit_p.sv
// Pipeline hazard/interlock controller with its own shadow pipeline and a
// post-jump hold window. Optional counters enabled by HAZARD_STATS_EN.
module hazard_unit_p
  import hazard_pkg::*;
#(
  parameter int RADDR_W     = 5,
  parameter int DEPTH       = 3,
  parameter int JUMP_SHADOW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [TYPE_W-1:0]  id_type,
  input  logic [RADDR_W-1:0] id_sel_a,
  input  logic [RADDR_W-1:0] id_sel_b,
  input  logic               id_b_reg,
  input  logic [RADDR_W-1:0] id_sel_c,
  input  logic               mr,
  output logic               hold,
  output logic               bubble,
  output logic               pipe_empty
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        jump_cnt
`endif
);

  localparam bit SHADOW_EN = (JUMP_SHADOW > 0);

  hz_entry_t [DEPTH-1:0] entries;
  hz_entry_t             id_entry;
  hz_state_e             state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [DEST_W-1:0]     sel_a_x, sel_b_x;
  logic [DEPTH-1:0]      m_any, m_wr, m_mr, m_c, m_ra, m_rb;
  logic                  hold_raw, issue_jump;

  assign sel_a_x  = DEST_W'(id_sel_a);
  assign sel_b_x  = DEST_W'(id_sel_b);
  assign id_entry = '{valid: id_valid, itype: id_type, dest: DEST_W'(id_sel_c)};

  hazard_shadow_pipe #(
    .DEPTH(DEPTH)
  ) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .bubble (hold),
    .din    (id_entry),
    .entries(entries)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [3:0] unused_ty;
    assign unused_ty = {entries[gi].itype[WR_READ], entries[gi].itype[R_READ],
                        entries[gi].itype[C_READ], entries[gi].itype[JUMP]};
    assign m_any[gi] = entries[gi].valid;
    assign m_wr[gi]  = entries[gi].valid & entries[gi].itype[WR_WRITE];
    assign m_c[gi]   = entries[gi].valid & entries[gi].itype[C_WRITE];
    assign m_ra[gi]  = entries[gi].valid & entries[gi].itype[R_WRITE] &
                       (entries[gi].dest == sel_a_x);
    assign m_rb[gi]  = entries[gi].valid & entries[gi].itype[R_WRITE] &
                       (entries[gi].dest == sel_b_x);
    // A memory read only conflicts once the writer has left e[1].
    if (gi >= 1) begin : g_mr
      assign m_mr[gi] = m_wr[gi];
    end else begin : g_no_mr
      assign m_mr[gi] = 1'b0;
    end
  end

  assign hold_raw = (id_valid & ((id_type[JUMP]    & (|m_any)) |
                                 (id_type[WR_READ] & (|m_wr))  |
                                 (id_type[C_READ]  & (|m_c))   |
                                 (id_type[R_READ]  & (|m_ra))  |
                                 (id_b_reg         & (|m_rb))))
                  | (mr & (|m_mr))
                  | (state_reg == SHADOW);

  assign hold       = ~reset & hold_raw;
  assign bubble     = hold;
  assign pipe_empty = reset | (~(|m_any) & (state_reg == IDLE));
  assign issue_jump = id_valid & id_type[JUMP] & ~hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (issue_jump && SHADOW_EN) begin
          state_next = SHADOW;
          cnt_next   = 4'(JUMP_SHADOW);
        end
      end
      SHADOW: begin
        // A zero count can only arise from corruption; treat it as the last cycle.
        if (cnt_reg <= 4'd1) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_reg, jump_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      jump_cnt_reg  <= '0;
    end else begin
      if (hold && stall_cnt_reg != 16'hFFFF) stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (issue_jump && jump_cnt_reg != 16'hFFFF) jump_cnt_reg <= jump_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign jump_cnt  = jump_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_unit_p.sv
// Directed scoreboard bench for hazard_unit_p (DEPTH=3, JUMP_SHADOW=2).
module tb_hazard_unit_p;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [6:0]  id_type;
  logic [4:0]  id_sel_a, id_sel_b, id_sel_c;
  logic        id_b_reg;
  logic        mr;
  logic        hold, bubble, pipe_empty;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, jump_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string tag;
    logic  hold;
    logic  empty;
  } exp_t;
  exp_t sb[$];

  localparam logic [6:0] T_WRW = 7'b000_0010;
  localparam logic [6:0] T_WRR = 7'b000_0001;
  localparam logic [6:0] T_RR  = 7'b000_0100;
  localparam logic [6:0] T_RW  = 7'b000_1000;
  localparam logic [6:0] T_CR  = 7'b001_0000;
  localparam logic [6:0] T_CW  = 7'b010_0000;
  localparam logic [6:0] T_J   = 7'b100_0000;

  always #5 clk = ~clk;

  hazard_unit_p #(
    .RADDR_W(5),
    .DEPTH(3),
    .JUMP_SHADOW(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_type   (id_type),
    .id_sel_a  (id_sel_a),
    .id_sel_b  (id_sel_b),
    .id_b_reg  (id_b_reg),
    .id_sel_c  (id_sel_c),
    .mr        (mr),
    .hold      (hold),
    .bubble    (bubble),
    .pipe_empty(pipe_empty)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .jump_cnt  (jump_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one decode cycle, queue its expectation, compare at the falling edge.
  task automatic step(input logic v, input logic [6:0] t, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] c, input logic breg,
                      input logic eh, input logic ee, input string tag);
    exp_t e;
    id_valid = v;
    id_type  = t;
    id_sel_a = a;
    id_sel_b = b;
    id_sel_c = c;
    id_b_reg = breg;
    sb.push_back('{tag, eh, ee});
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_hold"},   16'(hold),       16'(e.hold));
    chk({e.tag, "_bubble"}, 16'(bubble),     16'(e.hold));
    chk({e.tag, "_empty"},  16'(pipe_empty), 16'(e.empty));
    $display("[TB] %s hold=%b bubble=%b empty=%b", e.tag, hold, bubble, pipe_empty);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic eh, input logic ee, input string tag);
    step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, eh, ee, tag);
  endtask

  // Writer then reader; a stalled reader waits DEPTH cycles, then both drain.
  task automatic hz_seq(input logic [6:0] wt, input logic [4:0] wd, input logic [6:0] rt,
                        input logic [4:0] ra, input logic [4:0] rb, input logic breg,
                        input logic stall, input string tag);
    step(1'b1, wt, 5'd0, 5'd0, wd, 1'b0, 1'b0, 1'b1, {tag, "_wr"});
    if (stall) begin
      for (int i = 0; i < 3; i++) step(1'b1, rt, ra, rb, 5'd0, breg, 1'b1, 1'b0, {tag, "_stall"});
      step(1'b1, rt, ra, rb, 5'd0, breg, 1'b0, 1'b1, {tag, "_issue"});
    end else begin
      step(1'b1, rt, ra, rb, 5'd0, breg, 1'b0, 1'b0, {tag, "_issue"});
    end
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0, {tag, "_drain"});
    idle(1'b0, 1'b1, {tag, "_empty"});
  endtask

  initial begin
    reset = 1'b1;
    mr    = 1'b1;
    // Hazard-looking inputs during reset must still be masked.
    step(1'b1, T_J | T_WRR, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, "rst0");
    step(1'b1, T_J | T_WRR, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, "rst1");
    reset = 1'b0;
    mr    = 1'b0;

    hz_seq(T_RW,  5'd5, T_RR,  5'd5, 5'd0, 1'b0, 1'b1, "rawa");
    hz_seq(T_RW,  5'd5, T_RR,  5'd6, 5'd5, 1'b0, 1'b0, "rawa_miss");
    hz_seq(T_RW,  5'd9, 7'd0,  5'd2, 5'd9, 1'b1, 1'b1, "rawb");
    hz_seq(T_RW,  5'd9, 7'd0,  5'd2, 5'd9, 1'b0, 1'b0, "rawb_noreg");
    hz_seq(T_RW,  5'd0, T_RR,  5'd0, 5'd0, 1'b0, 1'b1, "reg0");
    hz_seq(T_WRW, 5'd0, T_WRR, 5'd0, 5'd0, 1'b0, 1'b1, "wr");
    hz_seq(T_CW,  5'd0, T_CR,  5'd0, 5'd0, 1'b0, 1'b1, "carry");
    hz_seq(T_RW,  5'd0, T_CR,  5'd0, 5'd0, 1'b0, 1'b0, "carry_miss");

    // Jump into an empty pipe: two shadow cycles, then drains.
    step(1'b1, T_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "jmp_issue");
    idle(1'b1, 1'b0, "jmp_sh1");
    idle(1'b1, 1'b0, "jmp_sh2");
    idle(1'b0, 1'b0, "jmp_e3");
    idle(1'b0, 1'b1, "jmp_empty");

    // Jump held by an in-flight entry starts its shadow only once issued.
    step(1'b1, T_RW, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, "jh_wr");
    for (int i = 0; i < 3; i++) step(1'b1, T_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, "jh_held");
    step(1'b1, T_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "jh_issue");
    idle(1'b1, 1'b0, "jh_sh1");
    idle(1'b1, 1'b0, "jh_sh2");
    idle(1'b0, 1'b0, "jh_e3");
    idle(1'b0, 1'b1, "jh_empty");

    // Memory read only stalls once the writer has moved past e[1].
    mr = 1'b1;
    step(1'b1, T_WRW, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "mr_wr");
    idle(1'b0, 1'b0, "mr_e1");
    idle(1'b1, 1'b0, "mr_e2");
    idle(1'b1, 1'b0, "mr_e3");
    idle(1'b0, 1'b1, "mr_done");
    mr = 1'b0;

    // Reset one cycle after a jump aborts the shadow.
    step(1'b1, T_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "rs_jump");
    reset = 1'b1;
    idle(1'b0, 1'b1, "rs_pulse");
    reset = 1'b0;
    idle(1'b0, 1'b1, "rs_after");
    idle(1'b0, 1'b1, "rs_after2");

`ifdef HAZARD_STATS_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("st_rst_stall", stall_cnt, 16'd0);
    chk("st_rst_jump",  jump_cnt,  16'd0);
    @(posedge clk);
    #1;
    step(1'b1, T_J, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, "st_jump");
    idle(1'b1, 1'b0, "st_sh1");
    idle(1'b1, 1'b0, "st_sh2");
    idle(1'b0, 1'b0, "st_e3");
    idle(1'b0, 1'b1, "st_empty");
    chk("st_jump_cnt",  jump_cnt,  16'd1);
    chk("st_stall_cnt", stall_cnt, 16'd2);
    // Saturating stream: holds three of every four cycles, well past 65535.
    mr       = 1'b1;
    id_valid = 1'b1;
    id_type  = T_WRR | T_WRW;
    repeat (89000) @(posedge clk);
    #1;
    chk("st_stall_sat", stall_cnt, 16'hFFFF);
    chk("st_jump_keep", jump_cnt,  16'd1);
    $display("[TB] stats stall_cnt=%h jump_cnt=%h", stall_cnt, jump_cnt);
    mr       = 1'b0;
    id_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("st_clr_stall", stall_cnt, 16'd0);
    chk("st_clr_jump",  jump_cnt,  16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
